// File: rtl/gpio_ctrl_gen2.sv
// rtl/gpio_ctrl_gen2.sv - GPIO controller: direction/output regs, synchronised and debounced inputs, edge/level interrupts
//
// Optional feature macro: GPIO_DEBOUNCE_EN
//   defined     -> per-pin debounce counters and the DB_CFG register are built
//   not defined -> filtered input follows the synchroniser directly, DB_CFG reads 0
//
// Ports:
//   mclk, h_reset        clock, synchronous active-high reset
//   reg_cs/reg_wr        register access request / write strobe
//   reg_addr/reg_wdata   word index / write data
//   reg_be               byte enables for RW registers
//   reg_rdata/reg_ack    registered read data / one-cycle acknowledge
//   cfg_gpio_dir_sel     per-pin output enable
//   pad_gpio_in          asynchronous pad inputs
//   pad_gpio_out         output data register
//   gpio_intr            level interrupt (any masked status bit)
module gpio_ctrl_gen2 #(
    parameter int NUM_GPIO    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 8
) (
    input  logic                mclk,
    input  logic                h_reset,
    input  logic                reg_cs,
    input  logic                reg_wr,
    input  logic [3:0]          reg_addr,
    input  logic [31:0]         reg_wdata,
    input  logic [3:0]          reg_be,
    output logic [31:0]         reg_rdata,
    output logic                reg_ack,
    output logic [NUM_GPIO-1:0] cfg_gpio_dir_sel,
    input  logic [NUM_GPIO-1:0] pad_gpio_in,
    output logic [NUM_GPIO-1:0] pad_gpio_out,
    output logic                gpio_intr
);

    localparam logic [3:0] A_DIR     = 4'd0;
    localparam logic [3:0] A_OUT     = 4'd1;
    localparam logic [3:0] A_IN      = 4'd2;
    localparam logic [3:0] A_ITYPE   = 4'd3;
    localparam logic [3:0] A_ISEL_P  = 4'd4;
    localparam logic [3:0] A_ISEL_N  = 4'd5;
    localparam logic [3:0] A_IMASK   = 4'd6;
    localparam logic [3:0] A_ISTAT   = 4'd7;
    localparam logic [3:0] A_OUT_SET = 4'd8;
    localparam logic [3:0] A_OUT_CLR = 4'd9;
    localparam logic [3:0] A_DB_CFG  = 4'd10;

    logic [NUM_GPIO-1:0] dir_q, out_q, itype_q, iselp_q, iseln_q, imask_q, istat_q;
    logic [NUM_GPIO-1:0] filt_q, prev_q;
    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_GPIO-1:0] sync_in, wdata_n, bem_n, w1c, rise, fall, lvl_hit, edge_hit, set_ev;
    logic [31:0]         be_mask, rd_val, db_rd;
    logic                acc, wr_en, rd_en;

    // An access is accepted only when no ack is outstanding, which spaces
    // back-to-back requests to one completion every other cycle.
    assign acc   = reg_cs & ~reg_ack;
    assign wr_en = acc & reg_wr;
    assign rd_en = acc & ~reg_wr;

    assign be_mask = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
    assign bem_n   = be_mask[NUM_GPIO-1:0];
    assign wdata_n = reg_wdata[NUM_GPIO-1:0];
    assign sync_in = sync_q[SYNC_STAGES-1];

    function automatic logic [NUM_GPIO-1:0] merge(input logic [NUM_GPIO-1:0] old_v,
                                                  input logic [NUM_GPIO-1:0] new_v,
                                                  input logic [NUM_GPIO-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [31:0] ext(input logic [NUM_GPIO-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_GPIO-1:0] = v;
        return r;
    endfunction

    // Event detection works on the filtered value regardless of direction,
    // so output pins raise events from their own loopback.
    always_comb begin
        rise     = filt_q & ~prev_q;
        fall     = ~filt_q & prev_q;
        lvl_hit  = (filt_q & iselp_q) | (~filt_q & iseln_q);
        edge_hit = (rise & iselp_q) | (fall & iseln_q);
        set_ev   = (itype_q & lvl_hit) | (~itype_q & edge_hit);
        w1c      = (wr_en && reg_addr == A_ISTAT) ? wdata_n : '0;
    end

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            A_DIR:    rd_val = ext(dir_q);
            A_OUT:    rd_val = ext(out_q);
            A_IN:     rd_val = ext(filt_q);
            A_ITYPE:  rd_val = ext(itype_q);
            A_ISEL_P: rd_val = ext(iselp_q);
            A_ISEL_N: rd_val = ext(iseln_q);
            A_IMASK:  rd_val = ext(imask_q);
            A_ISTAT:  rd_val = ext(istat_q);
            A_DB_CFG: rd_val = db_rd;
            default:  rd_val = '0;
        endcase
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [DB_CNT_W:0] CNT_ONE = 1;

    logic [DB_CNT_W-1:0] db_cfg_q;
    logic [DB_CNT_W-1:0] db_cnt_q [NUM_GPIO];

    always_comb begin
        db_rd = '0;
        db_rd[DB_CNT_W-1:0] = db_cfg_q;
    end

    // Counter counts consecutive cycles where the synchronised input
    // disagrees with the filtered value; reaching DB_CFG flips the filter.
    always_ff @(posedge mclk) begin
        if (h_reset) begin
            db_cfg_q <= '0;
            filt_q   <= '0;
            for (int i = 0; i < NUM_GPIO; i++) db_cnt_q[i] <= '0;
        end else begin
            if (wr_en && reg_addr == A_DB_CFG)
                db_cfg_q <= (db_cfg_q & ~be_mask[DB_CNT_W-1:0]) |
                            (reg_wdata[DB_CNT_W-1:0] & be_mask[DB_CNT_W-1:0]);
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (db_cfg_q == '0) begin
                    filt_q[i]   <= sync_in[i];
                    db_cnt_q[i] <= '0;
                end else if (sync_in[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (({1'b0, db_cnt_q[i]} + CNT_ONE) >= {1'b0, db_cfg_q}) begin
                    filt_q[i]   <= sync_in[i];
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] != '1) begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    assign db_rd = '0;

    always_ff @(posedge mclk) begin
        if (h_reset) filt_q <= '0;
        else         filt_q <= sync_in;
    end
`endif

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
            gpio_intr <= 1'b0;
            dir_q     <= '0;
            out_q     <= '0;
            itype_q   <= '0;
            iselp_q   <= '0;
            iseln_q   <= '0;
            imask_q   <= '0;
            istat_q   <= '0;
            prev_q    <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            reg_ack   <= acc;
            reg_rdata <= rd_en ? rd_val : '0;
            sync_q[0] <= pad_gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q    <= filt_q;
            // A new event in the same cycle as its W1C survives; level
            // sources keep re-setting the bit until the condition ends.
            istat_q   <= (istat_q & ~w1c) | set_ev;
            gpio_intr <= |(istat_q & imask_q);
            if (wr_en) begin
                case (reg_addr)
                    A_DIR:     dir_q   <= merge(dir_q, wdata_n, bem_n);
                    A_OUT:     out_q   <= merge(out_q, wdata_n, bem_n);
                    A_ITYPE:   itype_q <= merge(itype_q, wdata_n, bem_n);
                    A_ISEL_P:  iselp_q <= merge(iselp_q, wdata_n, bem_n);
                    A_ISEL_N:  iseln_q <= merge(iseln_q, wdata_n, bem_n);
                    A_IMASK:   imask_q <= merge(imask_q, wdata_n, bem_n);
                    A_OUT_SET: out_q   <= out_q | wdata_n;
                    A_OUT_CLR: out_q   <= out_q & ~wdata_n;
                    default: ;
                endcase
            end
        end
    end

    assign cfg_gpio_dir_sel = dir_q;
    assign pad_gpio_out     = out_q;

endmodule
